// File: rtl/best_err_pkg.sv
`default_nettype none
// =============================================================================
// best_err_pkg : shared widths, state encoding and improvement rule for
//                best_error_tracker.
// Rev 1.0
// =============================================================================
package best_err_pkg;

  // Widest error word the improvement helper can compare.
  localparam int MAX_EW = 128;

  function automatic int calc_ew(input int element_width, input int extra);
    return element_width + extra;
  endfunction

  function automatic int calc_aw(input int num_unknowns);
    return (num_unknowns > 1) ? $clog2(num_unknowns) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Operands arrive zero-extended; the sign of the current error comes separately.
  function automatic logic is_improvement(
    input logic              cur_neg,
    input logic [MAX_EW-1:0] cur,
    input logic [MAX_EW-1:0] best,
    input logic              best_valid,
    input logic [MAX_EW-1:0] min_delta
  );
    logic better;
    better = !cur_neg && (!best_valid || (cur < best));
    if (better && best_valid) begin
      better = ((best - cur) >= min_delta);
    end
    return better;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wr_burst_ctrl.sv
`default_nettype none
// =============================================================================
// wr_burst_ctrl : stallable NUM_UNKNOWNS-cycle write_en / wr_addr sequencer
//                 with start and done pulses.
// Rev 1.0
// =============================================================================
module wr_burst_ctrl #(
  parameter int NUM_UNKNOWNS = 2,
  parameter int AW           = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_start,
  input  logic          i_stall,
  output logic          o_write_en,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_done
);

  localparam logic [AW-1:0] C_LAST = AW'(NUM_UNKNOWNS - 1);

  logic          r_active;
  logic [AW-1:0] r_addr;
  logic          w_step;
  logic          w_last;

  assign w_step = r_active & ~i_stall;
  assign w_last = (r_addr == C_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_active <= 1'b0;
      r_addr   <= '0;
    end else if (i_clear) begin
      r_active <= 1'b0;
      r_addr   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_addr   <= '0;
    end else if (w_step) begin
      if (w_last) begin
        r_active <= 1'b0;
        r_addr   <= '0;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // A stalled cycle drops the strobe but keeps the address for the retry.
  assign o_write_en = w_step;
  assign o_wr_addr  = r_addr;
  assign o_done     = w_step & w_last;

endmodule
`default_nettype wire

// File: rtl/best_error_tracker.sv
`default_nettype none
// =============================================================================
// best_error_tracker : keeps the lowest non-negative training error, fires a
//                      per-unknown write burst on each improvement and raises
//                      a sticky convergence flag.
// Optional: BEST_ERR_HYST_EN adds i_min_delta hysteresis on improvements.
// Rev 1.0
// =============================================================================
module best_error_tracker
  import best_err_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 32,
  parameter int EXTRA         = 2,
  parameter int NUM_UNKNOWNS  = 2,
  parameter int PATIENCE      = 16,
  parameter int AW            = calc_aw(NUM_UNKNOWNS),
  // Derived from ELEMENT_WIDTH and EXTRA; not meant to be overridden.
  parameter int EW            = calc_ew(ELEMENT_WIDTH, EXTRA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_restart,
  input  logic          i_err_valid,
  output logic          o_err_ready,
  input  logic [EW-1:0] i_current_err,
  input  logic [EW-1:0] i_err_thresh,
  input  logic          i_stall,
`ifdef BEST_ERR_HYST_EN
  input  logic [EW-1:0] i_min_delta,
`endif
  output logic [EW-1:0] o_best_error,
  output logic          o_best_valid,
  output logic          o_write_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [7:0]    o_no_improve_cnt,
  output logic          o_converged
);

  localparam bit         C_PAT_EN   = (PATIENCE > 0);
  localparam logic [8:0] C_PATIENCE = (PATIENCE > 255) ? 9'd256 : 9'(PATIENCE);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [EW-1:0] r_best;
  logic          r_best_valid;
  logic [7:0]    r_cnt;
  logic          r_converged;

  logic          w_accept;
  logic          w_cur_neg;
  logic          w_improve;
  logic          w_thresh_hit;
  logic          w_patience_hit;
  logic [7:0]    w_cnt_inc;
  logic [EW-1:0] w_min_delta;
  logic          w_burst_start;
  logic          w_burst_done;

`ifdef BEST_ERR_HYST_EN
  assign w_min_delta = i_min_delta;
`else
  assign w_min_delta = '0;
`endif

  assign w_accept  = i_err_valid & o_err_ready;
  assign w_cur_neg = i_current_err[EW-1];
  assign w_improve = is_improvement(w_cur_neg, MAX_EW'(i_current_err), MAX_EW'(r_best),
                                    r_best_valid, MAX_EW'(w_min_delta));

  assign w_cnt_inc      = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_thresh_hit   = w_improve & (i_current_err <= i_err_thresh);
  assign w_patience_hit = C_PAT_EN & ({1'b0, w_cnt_inc} >= C_PATIENCE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (i_restart) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the threshold path reaches DONE only once the burst ends.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_improve) begin
          w_state_nxt = ST_WRITE;
        end else if (w_accept && !w_cur_neg && w_patience_hit) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (w_burst_done) begin
          w_state_nxt = r_converged ? ST_DONE : ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_err_ready   = (r_state == ST_IDLE);
    w_burst_start = w_accept & w_improve;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_cnt        <= '0;
      r_converged  <= 1'b0;
    end else if (i_restart) begin
      r_best       <= '0;
      r_best_valid <= 1'b0;
      r_cnt        <= '0;
      r_converged  <= 1'b0;
    end else if (w_accept && !w_cur_neg) begin
      if (w_improve) begin
        r_best       <= i_current_err;
        r_best_valid <= 1'b1;
        r_cnt        <= '0;
        if (w_thresh_hit) begin
          r_converged <= 1'b1;
        end
      end else begin
        r_cnt <= w_cnt_inc;
        if (w_patience_hit) begin
          r_converged <= 1'b1;
        end
      end
    end
  end

  wr_burst_ctrl #(
    .NUM_UNKNOWNS(NUM_UNKNOWNS),
    .AW          (AW)
  ) u_burst (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (i_restart),
    .i_start   (w_burst_start),
    .i_stall   (i_stall),
    .o_write_en(o_write_en),
    .o_wr_addr (o_wr_addr),
    .o_done    (w_burst_done)
  );

  assign o_best_error     = r_best;
  assign o_best_valid     = r_best_valid;
  assign o_no_improve_cnt = r_cnt;
  assign o_converged      = r_converged;

endmodule
`default_nettype wire

// File: tb/tb_best_error_tracker.sv
`default_nettype none
// =============================================================================
// tb_best_error_tracker : directed plus randomized bench for best_error_tracker
//                         with a queue scoreboard on the write burst.
// Rev 1.0
// =============================================================================
module tb_best_error_tracker;

  localparam int ELEMENT_WIDTH = 32;
  localparam int EXTRA         = 2;
  localparam int EW            = ELEMENT_WIDTH + EXTRA;
  localparam int NUM_UNKNOWNS  = 2;
  localparam int PATIENCE      = 3;
  localparam int AW            = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_restart = 1'b0;
  logic          i_err_valid = 1'b0;
  logic          i_stall = 1'b0;
  logic [EW-1:0] i_current_err = '0;
  logic [EW-1:0] i_err_thresh = '0;
`ifdef BEST_ERR_HYST_EN
  logic [EW-1:0] i_min_delta = EW'(5);
`endif
  logic          o_err_ready;
  logic [EW-1:0] o_best_error;
  logic          o_best_valid;
  logic          o_write_en;
  logic [AW-1:0] o_wr_addr;
  logic [7:0]    o_no_improve_cnt;
  logic          o_converged;

  best_error_tracker #(
    .ELEMENT_WIDTH(ELEMENT_WIDTH),
    .EXTRA        (EXTRA),
    .NUM_UNKNOWNS (NUM_UNKNOWNS),
    .PATIENCE     (PATIENCE),
    .AW           (AW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_restart       (i_restart),
    .i_err_valid     (i_err_valid),
    .o_err_ready     (o_err_ready),
    .i_current_err   (i_current_err),
    .i_err_thresh    (i_err_thresh),
    .i_stall         (i_stall),
`ifdef BEST_ERR_HYST_EN
    .i_min_delta     (i_min_delta),
`endif
    .o_best_error    (o_best_error),
    .o_best_valid    (o_best_valid),
    .o_write_en      (o_write_en),
    .o_wr_addr       (o_wr_addr),
    .o_no_improve_cnt(o_no_improve_cnt),
    .o_converged     (o_converged)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [EW-1:0] best;
  } wr_t;

  wr_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: best-so-far, patience counter, convergence.
  logic [EW-1:0] m_best;
  bit            m_valid;
  int            m_cnt;
  bit            m_conv;
  bit            m_done;

  task automatic model_reset();
    m_best  = '0;
    m_valid = 1'b0;
    m_cnt   = 0;
    m_conv  = 1'b0;
    m_done  = 1'b0;
  endtask

  task automatic model_accept(input logic [EW-1:0] v, input logic [EW-1:0] thr, output bit burst);
    bit gain;
    burst = 1'b0;
    if (v[EW-1]) return;
    gain = !m_valid || (v < m_best);
`ifdef BEST_ERR_HYST_EN
    if (gain && m_valid && ((m_best - v) < i_min_delta)) gain = 1'b0;
`endif
    if (gain) begin
      m_best  = v;
      m_valid = 1'b1;
      m_cnt   = 0;
      burst   = 1'b1;
      for (int a = 0; a < NUM_UNKNOWNS; a++) sb.push_back('{AW'(a), v});
      if (v <= thr) begin
        m_conv = 1'b1;
        m_done = 1'b1;
      end
    end else begin
      if (m_cnt < 255) m_cnt++;
      if (PATIENCE > 0 && m_cnt >= PATIENCE) begin
        m_conv = 1'b1;
        m_done = 1'b1;
      end
    end
  endtask

  // Stall driver: random or forced, updated just after each rising edge.
  bit rand_stall_en = 1'b0;
  bit force_stall   = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      i_stall = force_stall | (rand_stall_en && ($urandom_range(0, 9) < 3));
    end
  end

  // Monitor: every write strobe must match the next expected burst entry.
  always @(negedge clk) begin : mon
    wr_t e;
    if (!rst) begin
      if (i_stall) chk("stall_gate", 64'(o_write_en), 64'd0);
      if (o_write_en) begin
        chk("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
          chk("wr_best", 64'(o_best_error), 64'(e.best));
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_best"},  64'(o_best_error),     64'd0);
    chk({tag, "_valid"}, 64'(o_best_valid),     64'd0);
    chk({tag, "_wen"},   64'(o_write_en),       64'd0);
    chk({tag, "_addr"},  64'(o_wr_addr),        64'd0);
    chk({tag, "_cnt"},   64'(o_no_improve_cnt), 64'd0);
    chk({tag, "_conv"},  64'(o_converged),      64'd0);
    chk({tag, "_ready"}, 64'(o_err_ready),      64'd1);
  endtask

  task automatic wait_ready(output bit ok);
    int n;
    n = 0;
    while (!o_err_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    ok = o_err_ready;
  endtask

  task automatic do_restart();
    i_restart = 1'b1;
    @(posedge clk);
    #1;
    i_restart = 1'b0;
    sb.delete();
    model_reset();
    chk_reset_vals("restart");
  endtask

  task automatic settle();
    bit ok;
    wait_ready(ok);
    chk("settle_ready", 64'(ok), 64'd1);
    chk("settle_sb", 64'(sb.size()), 64'd0);
  endtask

  task automatic epoch(input logic [EW-1:0] v, input logic [EW-1:0] thr);
    bit ok;
    bit burst;
    int n;
    wait_ready(ok);
    chk("ready_before_accept", 64'(ok), 64'd1);
    if (!ok) begin
      do_restart();
      return;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    i_current_err = v;
    i_err_thresh  = thr;
    i_err_valid   = 1'b1;
    @(posedge clk);
    #1;
    i_err_valid = 1'b0;
    model_accept(v, thr, burst);
    chk("best_error", 64'(o_best_error),     64'(m_best));
    chk("best_valid", 64'(o_best_valid),     64'(m_valid));
    chk("no_improve", 64'(o_no_improve_cnt), 64'(m_cnt));
    chk("converged",  64'(o_converged),      64'(m_conv));
    chk("err_ready",  64'(o_err_ready),      64'(!burst && !m_done));
    if (m_done) begin
      n = 0;
      while (sb.size() != 0 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("done_drain", 64'(sb.size()), 64'd0);
      // Producer keeps offering data; DONE must never take it.
      i_current_err = '0;
      i_err_valid   = 1'b1;
      repeat (3) begin
        @(posedge clk);
        #1;
        chk("done_ready", 64'(o_err_ready),  64'd0);
        chk("done_wen",   64'(o_write_en),   64'd0);
        chk("done_best",  64'(o_best_error), 64'(m_best));
      end
      i_err_valid = 1'b0;
    end
  endtask

  initial begin
    logic [EW-1:0] v;
    logic [EW-1:0] thr;
    model_reset();
    #2 rst = 1'b1;
    #4;
    chk("in_reset_wen",   64'(o_write_en),   64'd0);
    chk("in_reset_valid", 64'(o_best_valid), 64'd0);
    #6 rst = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("reset");

    // Bursts on 100 and 80 only; 90 counts as no improvement.
    epoch(EW'(100), '0);
    epoch(EW'(80), '0);
    epoch(EW'(90), '0);
    settle();

    // Negative error with no best yet is ignored; 50 then bursts.
    do_restart();
    epoch(EW'(-5), '0);
    epoch(EW'(50), '0);

    // Stall held three cycles while wr_addr sits at 1.
    epoch(EW'(30), '0);
    chk("stall_first_wen",  64'(o_write_en), 64'd1);
    chk("stall_first_addr", 64'(o_wr_addr),  64'd0);
    @(negedge clk);
    force_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_wen",   64'(o_write_en),  64'd0);
      chk("stall_addr",  64'(o_wr_addr),   64'd1);
      chk("stall_ready", 64'(o_err_ready), 64'd0);
    end
    force_stall = 1'b0;
    settle();

    // Patience convergence: best 10, then 12, 11, 10.
    do_restart();
    epoch(EW'(10), '0);
    epoch(EW'(12), '0);
    epoch(EW'(11), '0);
    epoch(EW'(10), '0);
    do_restart();

    // Threshold convergence after the burst.
    epoch(EW'(15), EW'(20));
    do_restart();

    // Asynchronous reset in the middle of a burst.
    epoch(EW'(40), '0);
    @(posedge clk);
    #1;
    chk("pre_rst_addr", 64'(o_wr_addr),  64'd1);
    chk("pre_rst_wen",  64'(o_write_en), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    sb.delete();
    model_reset();
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef BEST_ERR_HYST_EN
    epoch(EW'(100), '0);
    epoch(EW'(97), '0);
    epoch(EW'(94), '0);
    settle();
    do_restart();
`endif

    rand_stall_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) v = EW'(-int'($urandom_range(1, 1000)));
      else v = EW'($urandom_range(0, 400));
      thr = ($urandom_range(0, 4) == 0) ? EW'($urandom_range(0, 60)) : '0;
      epoch(v, thr);
      if (m_done) do_restart();
    end
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/best_error_tracker.md
Name: best_error_tracker

Overview:
- Tracks the lowest non-negative training error seen so far.
- On every improvement, issues a write-enable burst with a per-unknown address so the best-weights memory captures the current roots.
- Adds a valid/ready input handshake, stall-frozen bursts, a no-improvement patience counter and a threshold-based convergence flag.
- Sits between the error-calculation stage and the best-weights memory / training controller.

Parameters:
- ELEMENT_WIDTH, 32, base error word width.
- EXTRA, 2, guard bits; error width EW = ELEMENT_WIDTH+EXTRA.
- NUM_UNKNOWNS, 2, write_en burst length; one cycle per unknown.
- PATIENCE, 16, consecutive non-improving epochs before convergence; 0 disables this convergence path.
- AW, $clog2(NUM_UNKNOWNS) (min 1), width of wr_addr.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset; asynchronous, active-high.
- restart, input, 1, synchronous clear of tracker state, identical in effect to reset.
- err_valid, input, 1, current_err is valid.
- err_ready, output, 1, tracker accepts an error this cycle.
- current_err, input, EW, signed two's-complement epoch error.
- err_thresh, input, EW, convergence threshold; treated as unsigned.
- stall, input, 1, freezes the write burst.
- best_error, output, EW, lowest accepted error.
- best_valid, output, 1, best_error holds a real value.
- write_en, output, 1, best-weights memory write strobe.
- wr_addr, output, AW, unknown index for write_en.
- no_improve_cnt, output, 8, saturating epochs-without-improvement count.
- converged, output, 1, sticky convergence flag.

Behaviour:
- Reset values: best_error=0, best_valid=0, write_en=0, wr_addr=0, no_improve_cnt=0, converged=0, state=IDLE. restart restores the same values synchronously and has priority over all other inputs.
- Acceptance: an error is accepted when err_valid && err_ready. err_ready=1 only in IDLE.
- Negative errors (current_err[EW-1]=1) are accepted but ignored; no counter changes.
- Improvement = current_err non-negative AND (best_valid==0 OR current_err < best_error, unsigned compare).
- IDLE, on accepted improvement:
  - next cycle best_error=current_err, best_valid=1, no_improve_cnt=0, state=WRITE, write_en=1, wr_addr=0.
  - write_en is asserted one cycle after acceptance.
- IDLE, on accepted non-negative non-improvement (including equal value): no_improve_cnt increments, saturating at 255.
- WRITE:
  - write_en=1 every cycle; wr_addr advances by 1 per non-stalled cycle.
  - When stall=1, write_en drops to 0 and wr_addr holds.
  - After the write at wr_addr=NUM_UNKNOWNS-1 completes with stall=0, write_en=0, wr_addr=0, state=IDLE.
  - An unstalled burst lasts exactly NUM_UNKNOWNS cycles.
- Convergence:
  - converged sets in the cycle after an acceptance that either makes best_error <= err_thresh or makes no_improve_cnt reach PATIENCE (PATIENCE>0).
  - On the threshold path, state goes to DONE after the burst completes.
  - DONE: err_ready=0, write_en=0; only rst or restart exits.
- Stall in IDLE has no effect. err_valid in WRITE/DONE is not accepted; the producer holds its data.
- NUM_UNKNOWNS=1: single-cycle burst, wr_addr constant 0.

Optional Feature:
- Macro: BEST_ERR_HYST_EN.
- Defined: adds input min_delta (EW bits). An improvement additionally requires best_error - current_err >= min_delta when best_valid=1. This suppresses burst writes on marginal gains; marginal gains count as non-improvement.
- Undefined: no port, strict less-than rule only.

Decomposition:
- Package best_err_pkg:
  - EW derivation.
  - State enum IDLE/WRITE/DONE.
  - Function is_improvement(cur, best, best_valid[, min_delta]).
- One sub-module is natural: wr_burst_ctrl, owning the stallable NUM_UNKNOWNS-cycle write_en/wr_addr sequencer with start/done pulses.

Test Plan:
- Reset, then errors 100, 80, 90: bursts after 100 and 80 only; best_error=80; no_improve_cnt=1; write_en high 2 cycles per burst with wr_addr 0,1.
- Error -5 with best invalid: no burst, best_valid stays 0, cnt unchanged; then error 50 triggers a burst.
- Improvement with stall high for 3 cycles mid-burst: write_en low during stall, wr_addr held at 1, resumes, burst totals 2 write cycles; err_ready=0 throughout.
- PATIENCE=3, best=10, then 12, 11, 10: converged=1 after third; err_ready=0; no further acceptance until restart.
- err_thresh=20, error 15: burst completes, converged=1, state DONE; restart returns all outputs to reset values.
- Assert rst mid-burst at wr_addr=1: all outputs clear immediately, asynchronously.
- With BEST_ERR_HYST_EN and min_delta=5: best 100, error 97 gives no burst and cnt=1; error 94 gives a burst.
